// File: rtl/vec_uop_splitter_pkg.sv
// Shared types for the vector micro-op splitter and its consumers.
//   lmul_e        : log2(LMUL) encoding of the register-group size
//   split_state_e : splitter control state
//   uop_s         : micro-op bundle as seen by the vector issue queue
//   reg_add       : register-number advance with modulo-32 wrap
package vec_split_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int UOP_DATA_W = 32;
    localparam int UOP_CNT_W  = 8;

    typedef enum logic [1:0] {
        M1 = 2'd0,
        M2 = 2'd1,
        M4 = 2'd2,
        M8 = 2'd3
    } lmul_e;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } split_state_e;

    typedef struct packed {
        logic [UOP_DATA_W-1:0] data;
        logic [REG_ADDR_W-1:0] vd;
        logic [REG_ADDR_W-1:0] vs1;
        logic [REG_ADDR_W-1:0] vs2;
        logic [2:0]            uop_idx;
        logic [UOP_CNT_W-1:0]  elem_cnt;
        logic                  last;
    } uop_s;

    // Register groups may run past v31; the architectural number simply wraps.
    function automatic logic [REG_ADDR_W-1:0] reg_add(input logic [REG_ADDR_W-1:0] base,
                                                      input logic [2:0]            idx);
        return base + REG_ADDR_W'(idx);
    endfunction

endpackage

// File: rtl/vec_uop_splitter_count.sv
// vec_uop_count: combinational mapping of (vl, lmul) to the effective vector
// length and the number of register-group micro-ops it needs.
//   vl_i      : requested vector length
//   lmul_i    : log2(LMUL)
//   vl_eff_o  : vl clipped to the register-group capacity
//   n_uops_o  : ceil(vl_eff / ELEMS_PER_REG), 0..8
module vec_uop_count
    import vec_split_pkg::*;
#(
    parameter int ELEMS_PER_REG = 4,
    parameter int VL_W          = $clog2(8*ELEMS_PER_REG)+1
) (
    input  logic [VL_W-1:0] vl_i,
    input  lmul_e           lmul_i,
    output logic [VL_W-1:0] vl_eff_o,
    output logic [3:0]      n_uops_o
);

    localparam int EW  = $clog2(ELEMS_PER_REG);
    localparam int VW1 = VL_W + 1;

    logic [VL_W-1:0] cap;
    logic [VW1-1:0]  rounded;

    assign cap      = VL_W'(ELEMS_PER_REG) << 2'(lmul_i);
    assign vl_eff_o = (vl_i < cap) ? vl_i : cap;

    // Extra headroom bit so the round-up add cannot overflow at vl_eff = max.
    assign rounded  = {1'b0, vl_eff_o} + VW1'(ELEMS_PER_REG-1);
    assign n_uops_o = 4'(rounded >> EW);

endmodule

// File: rtl/vec_uop_splitter.sv
// vec_uop_splitter: cracks one vector instruction into 1..8 register-group
// micro-ops (by LMUL and vl) and issues them one per cycle.
//   Input side : valid_in/ready_out handshake with data/vd/vs1/vs2/lmul/vl
//   Output side: valid_out/ready_in handshake with data, advanced register
//                numbers, uop_idx, elem_cnt and last
//   flush      : synchronous kill of the held instruction
// Optional build macro VEC_UOP_SPLITTER_STATS_EN adds instr_cnt_out and
// uop_cnt_out (free-running accepted-instruction / accepted-micro-op counts).
module vec_uop_splitter
    import vec_split_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ELEMS_PER_REG = 4,
    parameter int VL_W          = $clog2(8*ELEMS_PER_REG)+1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic                              valid_in,
    output logic                              ready_out,
    input  logic [DATA_WIDTH-1:0]             data_in,
    input  logic [REG_ADDR_W-1:0]             vd_in,
    input  logic [REG_ADDR_W-1:0]             vs1_in,
    input  logic [REG_ADDR_W-1:0]             vs2_in,
    input  logic [1:0]                        lmul_in,
    input  logic [VL_W-1:0]                   vl_in,
    output logic                              valid_out,
    input  logic                              ready_in,
    output logic [DATA_WIDTH-1:0]             data_out,
    output logic [REG_ADDR_W-1:0]             vd_out,
    output logic [REG_ADDR_W-1:0]             vs1_out,
    output logic [REG_ADDR_W-1:0]             vs2_out,
    output logic [2:0]                        uop_idx_out,
    output logic [$clog2(ELEMS_PER_REG):0]    elem_cnt_out,
    output logic                              last_out
`ifdef VEC_UOP_SPLITTER_STATS_EN
    ,
    output logic [31:0]                       instr_cnt_out,
    output logic [31:0]                       uop_cnt_out
`endif
);

    localparam int EW    = $clog2(ELEMS_PER_REG);
    localparam int CNT_W = EW + 1;

    split_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [REG_ADDR_W-1:0] vd_q, vd_d, vs1_q, vs1_d, vs2_q, vs2_d;
    logic [2:0]            idx_q, idx_d;
    logic [2:0]            last_idx_q, last_idx_d;
    logic [VL_W-1:0]       vl_eff_q, vl_eff_d;

    logic [VL_W-1:0]       vl_eff_in;
    logic [3:0]            n_uops_in;
    logic [VL_W-1:0]       remaining;
    logic                  capture;
    logic                  out_fire;

    vec_uop_count #(
        .ELEMS_PER_REG (ELEMS_PER_REG),
        .VL_W          (VL_W)
    ) u_count (
        .vl_i     (vl_in),
        .lmul_i   (lmul_e'(lmul_in)),
        .vl_eff_o (vl_eff_in),
        .n_uops_o (n_uops_in)
    );

    assign valid_out = (state_q == SPLIT);
    // Gated by valid so that an idle block never shows a stale last flag.
    assign last_out  = valid_out & (idx_q == last_idx_q);

    // Combinational through ready_in: the next instruction is taken in the
    // same cycle the last micro-op leaves, giving bubble-free back-to-back.
    assign ready_out = ~flush & (~valid_out | (ready_in & last_out));
    assign capture   = valid_in & ready_out;
    assign out_fire  = valid_out & ready_in & ~flush;

    assign remaining    = vl_eff_q - (VL_W'(idx_q) << EW);
    assign elem_cnt_out = (remaining >= VL_W'(ELEMS_PER_REG)) ? CNT_W'(ELEMS_PER_REG)
                                                              : remaining[CNT_W-1:0];
    assign data_out     = data_q;
    assign vd_out       = reg_add(vd_q, idx_q);
    assign vs1_out      = reg_add(vs1_q, idx_q);
    assign vs2_out      = reg_add(vs2_q, idx_q);
    assign uop_idx_out  = idx_q;

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        vd_d       = vd_q;
        vs1_d      = vs1_q;
        vs2_d      = vs2_q;
        idx_d      = idx_q;
        last_idx_d = last_idx_q;
        vl_eff_d   = vl_eff_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            if (out_fire) begin
                if (last_out) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            // A capture can only coincide with the last micro-op leaving, so
            // it safely overrides the advance above.
            if (capture) begin
                data_d     = data_in;
                vd_d       = vd_in;
                vs1_d      = vs1_in;
                vs2_d      = vs2_in;
                idx_d      = 3'd0;
                vl_eff_d   = vl_eff_in;
                last_idx_d = 3'(n_uops_in - 4'd1);
                // vl=0 is consumed without producing any micro-op.
                state_d    = (n_uops_in != 4'd0) ? SPLIT : IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            data_q     <= '0;
            vd_q       <= '0;
            vs1_q      <= '0;
            vs2_q      <= '0;
            idx_q      <= '0;
            last_idx_q <= '0;
            vl_eff_q   <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            vd_q       <= vd_d;
            vs1_q      <= vs1_d;
            vs2_q      <= vs2_d;
            idx_q      <= idx_d;
            last_idx_q <= last_idx_d;
            vl_eff_q   <= vl_eff_d;
        end
    end

`ifdef VEC_UOP_SPLITTER_STATS_EN
    logic [31:0] instr_cnt_q, uop_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_cnt_q <= '0;
            uop_cnt_q   <= '0;
        end else begin
            if (capture)  instr_cnt_q <= instr_cnt_q + 32'd1;
            if (out_fire) uop_cnt_q   <= uop_cnt_q + 32'd1;
        end
    end

    assign instr_cnt_out = instr_cnt_q;
    assign uop_cnt_out   = uop_cnt_q;
`endif

endmodule

// File: tb/tb_vec_uop_splitter.sv
// Self-checking bench for vec_uop_splitter (ELEMS_PER_REG=4).
module tb_vec_uop_splitter;

    localparam int DW   = 32;
    localparam int E    = 4;
    localparam int VL_W = 6;

    logic            clk, rst, flush, valid_in, ready_out, ready_in, valid_out, last_out;
    logic [DW-1:0]   data_in, data_out;
    logic [4:0]      vd_in, vs1_in, vs2_in, vd_out, vs1_out, vs2_out;
    logic [1:0]      lmul_in;
    logic [VL_W-1:0] vl_in;
    logic [2:0]      uop_idx_out;
    logic [2:0]      elem_cnt_out;
`ifdef VEC_UOP_SPLITTER_STATS_EN
    logic [31:0]     instr_cnt_out, uop_cnt_out;
`endif

    vec_uop_splitter #(
        .DATA_WIDTH    (DW),
        .ELEMS_PER_REG (E),
        .VL_W          (VL_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .data_in      (data_in),
        .vd_in        (vd_in),
        .vs1_in       (vs1_in),
        .vs2_in       (vs2_in),
        .lmul_in      (lmul_in),
        .vl_in        (vl_in),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .data_out     (data_out),
        .vd_out       (vd_out),
        .vs1_out      (vs1_out),
        .vs2_out      (vs2_out),
        .uop_idx_out  (uop_idx_out),
        .elem_cnt_out (elem_cnt_out),
        .last_out     (last_out)
`ifdef VEC_UOP_SPLITTER_STATS_EN
        ,
        .instr_cnt_out (instr_cnt_out),
        .uop_cnt_out   (uop_cnt_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the list of micro-ops still owed for the held instruction.
    typedef struct {
        logic [31:0] data;
        logic [4:0]  vd, vs1, vs2;
        int          idx;
        int          elem;
        bit          last;
    } euop_t;

    euop_t q[$];
    int checks   = 0;
    int failures = 0;
    int m_instr  = 0;
    int m_uops   = 0;

    // Observations from the most recent cycle.
    bit         ov, ola, ordy;
    logic [4:0] ovd;
    int         oel;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push_instr(input logic [31:0] d, input logic [4:0] vd,
                                       input logic [4:0] vs1, input logic [4:0] vs2,
                                       input int lmul, input int vl);
        int cap = E << lmul;
        int eff = (vl < cap) ? vl : cap;
        int n   = (eff + E - 1) / E;
        euop_t u;
        for (int k = 0; k < n; k++) begin
            u.data = d;
            u.vd   = 5'((int'(vd) + k) % 32);
            u.vs1  = 5'((int'(vs1) + k) % 32);
            u.vs2  = 5'((int'(vs2) + k) % 32);
            u.idx  = k;
            u.elem = ((eff - k*E) < E) ? (eff - k*E) : E;
            u.last = (k == n-1);
            q.push_back(u);
        end
    endfunction

    // One clock: drive at negedge, check just after, update the model at posedge.
    task automatic cyc(input bit v, input bit rdy, input bit fl, input logic [31:0] d,
                       input logic [4:0] vd, input logic [4:0] vs1, input logic [4:0] vs2,
                       input logic [1:0] lm, input logic [5:0] vl);
        bit          exp_ready;
        logic [53:0] exp_vec;
        @(negedge clk);
        valid_in = v; ready_in = rdy; flush = fl; data_in = d;
        vd_in = vd; vs1_in = vs1; vs2_in = vs2; lmul_in = lm; vl_in = vl;
        #1;
        ov = valid_out; ovd = vd_out; oel = int'(elem_cnt_out); ola = last_out; ordy = ready_out;
        check("valid_out", 64'(valid_out), 64'(q.size() != 0));
        if (q.size() != 0) begin
            exp_vec = {q[0].data, q[0].vd, q[0].vs1, q[0].vs2, 3'(q[0].idx), 3'(q[0].elem), q[0].last};
            check("uop_fields", 64'({data_out, vd_out, vs1_out, vs2_out, uop_idx_out, elem_cnt_out, last_out}),
                  64'(exp_vec));
        end
        exp_ready = !fl && (q.size() == 0 || (rdy && q[0].last));
        check("ready_out", 64'(ready_out), 64'(exp_ready));
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (q.size() != 0 && rdy) begin
                void'(q.pop_front());
                m_uops++;
            end
            if (v && exp_ready) begin
                m_instr++;
                push_instr(d, vd, vs1, vs2, int'(lm), int'(vl));
            end
        end
    endtask

    task automatic idle_cyc(input bit rdy);
        cyc(1'b0, rdy, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 2'd0, 6'd0);
    endtask

    typedef struct {
        logic [1:0] lmul;
        logic [5:0] vl;
        logic [4:0] vd;
        int         exp_n;
        logic [4:0] exp_vd_last;
        int         exp_elem_last;
    } vec_t;

    vec_t tbl[8];
    int   cnt, last_elem;
    logic [4:0] last_vd;

    initial begin
        tbl[0] = '{2'd2, 6'd14, 5'd8,  4, 5'd11, 2};
        tbl[1] = '{2'd0, 6'd20, 5'd3,  1, 5'd3,  4};
        tbl[2] = '{2'd2, 6'd16, 5'd30, 4, 5'd1,  4};
        tbl[3] = '{2'd3, 6'd32, 5'd0,  8, 5'd7,  4};
        tbl[4] = '{2'd3, 6'd63, 5'd28, 8, 5'd3,  4};
        tbl[5] = '{2'd1, 6'd5,  5'd10, 2, 5'd11, 1};
        tbl[6] = '{2'd1, 6'd0,  5'd4,  0, 5'd0,  0};
        tbl[7] = '{2'd3, 6'd9,  5'd31, 3, 5'd1,  1};

        rst = 1'b0; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b0; data_in = '0;
        vd_in = '0; vs1_in = '0; vs2_in = '0; lmul_in = '0; vl_in = '0;
        #1 rst = 1'b1;
        #2;
        check("rst_valid", 64'(valid_out), 64'(0));
        check("rst_outputs", 64'({data_out, vd_out, vs1_out, vs2_out, uop_idx_out, elem_cnt_out, last_out}), 64'(0));
        check("rst_ready", 64'(ready_out), 64'(1));
        #9 rst = 1'b0;

        // Table of single instructions issued from idle with ready_in=1.
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 32'hA000 + 32'(i), tbl[i].vd, 5'(i), 5'(i+1), tbl[i].lmul, tbl[i].vl);
            cnt = 0; last_vd = '0; last_elem = 0;
            for (int c = 0; c < 10; c++) begin
                idle_cyc(1'b1);
                if (c == 0) check("first_latency", 64'(ov), 64'(tbl[i].exp_n != 0));
                if (ov) begin
                    cnt++; last_vd = ovd; last_elem = oel;
                    if (ola) break;
                end
            end
            check("tbl_uop_count", 64'(cnt), 64'(tbl[i].exp_n));
            if (tbl[i].exp_n != 0) begin
                check("tbl_last_vd", 64'(last_vd), 64'(tbl[i].exp_vd_last));
                check("tbl_last_elem", 64'(last_elem), 64'(tbl[i].exp_elem_last));
            end
        end

        // vl=0 immediately followed by an M2 vl=8 instruction.
        cyc(1'b1, 1'b1, 1'b0, 32'h1111, 5'd2, 5'd3, 5'd4, 2'd0, 6'd0);
        cyc(1'b1, 1'b1, 1'b0, 32'h2222, 5'd5, 5'd6, 5'd7, 2'd1, 6'd8);
        check("vl0_no_output", 64'(ov), 64'(0));
        idle_cyc(1'b1);
        check("after_vl0_first", 64'({ov, ovd, ola}), 64'({1'b1, 5'd5, 1'b0}));
        idle_cyc(1'b1);
        check("after_vl0_second", 64'({ov, ovd, ola}), 64'({1'b1, 5'd6, 1'b1}));

        // Back-to-back M2 instructions: no bubble, ready pulses with each last.
        cyc(1'b1, 1'b1, 1'b0, 32'h3333, 5'd12, 5'd0, 5'd0, 2'd1, 6'd8);
        for (int c = 0; c < 4; c++) begin
            if (c < 2) cyc(1'b1, 1'b1, 1'b0, 32'h4444, 5'd20, 5'd1, 5'd1, 2'd1, 6'd8);
            else       idle_cyc(1'b1);
            check("b2b_valid", 64'(ov), 64'(1));
            check("b2b_ready_pulse", 64'(ordy), 64'(c % 2));
        end

        // M8 with ready_in toggling; model checks stability while stalled.
        cyc(1'b1, 1'b1, 1'b0, 32'h5555, 5'd30, 5'd1, 5'd2, 2'd3, 6'd30);
        for (int c = 0; c < 16; c++) cyc(1'b0, 1'(c % 2), 1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 2'd0, 6'd0);
        for (int c = 0; c < 10; c++) idle_cyc(1'b1);

        // Flush at idx=2 with a new instruction offered in the same cycle.
        cyc(1'b1, 1'b1, 1'b0, 32'h6666, 5'd0, 5'd0, 5'd0, 2'd3, 6'd32);
        idle_cyc(1'b1);
        idle_cyc(1'b1);
        cyc(1'b1, 1'b1, 1'b1, 32'h7777, 5'd9, 5'd9, 5'd9, 2'd0, 6'd4);
        check("flush_idx", 64'(uop_idx_out), 64'(2));
        check("flush_blocks_input", 64'(ordy), 64'(0));
        idle_cyc(1'b1);
        check("flush_idle", 64'(ov), 64'(0));

        // Asynchronous reset while splitting.
        cyc(1'b1, 1'b1, 1'b0, 32'h8888, 5'd7, 5'd8, 5'd9, 2'd2, 6'd16);
        idle_cyc(1'b0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(valid_out), 64'(0));
        check("async_rst_outputs", 64'({data_out, vd_out, vs1_out, vs2_out, uop_idx_out, elem_cnt_out, last_out}), 64'(0));
        q.delete(); m_instr = 0; m_uops = 0;
        #1 rst = 1'b0;

        // Randomised traffic against the model.
        for (int c = 0; c < 600; c++) begin
            cyc(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 24) == 0), $urandom(), 5'($urandom()), 5'($urandom()),
                5'($urandom()), 2'($urandom()), 6'($urandom()));
        end
        for (int c = 0; c < 10; c++) idle_cyc(1'b1);

`ifdef VEC_UOP_SPLITTER_STATS_EN
        check("instr_cnt", 64'(instr_cnt_out), 64'(m_instr));
        check("uop_cnt", 64'(uop_cnt_out), 64'(m_uops));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
